// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch path.
// Contents: the fetch FSM state enum, default bus widths and the opcode field position
// (also used by the control unit decoder).
package instruction_fetch_unit_pkg;

  localparam int unsigned DefAddrW  = 8;
  localparam int unsigned DefDataW  = 16;
  localparam int unsigned OpcodeMsb = 15;
  localparam int unsigned OpcodeLsb = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWrite = 2'd2
  } fetch_state_e;

  function automatic logic [OpcodeMsb-OpcodeLsb:0] get_opcode(input logic [DefDataW-1:0] instr);
    return instr[OpcodeMsb:OpcodeLsb];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: control-unit request, instruction memory and IR load signals.
// Modports:
//   master - the fetch unit (drives mem_addr/mem_rd_en/ir_data/ir_wr_en/pc/status)
//   slave  - the surrounding system (drives fetch_start/pc_load/pc_load_val/mem_rdata/mem_valid)
interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
) ();

  logic              fetch_start;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_val;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] ir_data;
  logic              ir_wr_en;
  logic [ADDR_W-1:0] pc;
  logic              fetch_busy;
  logic              fetch_done;
  logic              fetch_err;

  modport master (
    input  fetch_start, pc_load, pc_load_val, mem_rdata, mem_valid,
    output mem_addr, mem_rd_en, ir_data, ir_wr_en, pc, fetch_busy, fetch_done, fetch_err
  );

  modport slave (
    output fetch_start, pc_load, pc_load_val, mem_rdata, mem_valid,
    input  mem_addr, mem_rd_en, ir_data, ir_wr_en, pc, fetch_busy, fetch_done, fetch_err
  );

endinterface

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter register: synchronous load (jump) with priority over increment,
// increment by PC_STEP with natural modulo-2^ADDR_W wraparound.
// Ports:
//   IR_clk, IR_rst - clock, asynchronous active-high reset (PC resets to 0)
//   load_i/load_val_i - load PC with a jump target
//   inc_i          - advance PC by PC_STEP
//   pc_o           - current PC
module program_counter
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned PC_STEP = 1
) (
  input  logic              IR_clk,
  input  logic              IR_rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge IR_clk or posedge IR_rst) begin
    if (IR_rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: on fetch_start, reads instruction memory at the PC, writes the
// returned word to the IR with a one-cycle strobe, then advances the PC.
// Ports:
//   IR_clk, IR_rst - clock, asynchronous active-high reset
//   bus            - instruction_fetch_unit_if master modport (request, memory, IR, status)
// Optional build macro FETCH_TIMEOUT_EN: abandon a memory read after TIMEOUT wait cycles
// and pulse fetch_err; without it REQ waits indefinitely and fetch_err is tied low.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned PC_STEP = 1,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                      IR_clk,
  input logic                      IR_rst,
  instruction_fetch_unit_if.master bus
);

  if (TIMEOUT == 0 || DATA_W <= OpcodeMsb) begin : g_param_err
    $error("instruction_fetch_unit: TIMEOUT must be >= 1 and DATA_W must hold the opcode");
  end

  fetch_state_e      state_q;
  logic [DATA_W-1:0] ir_data_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] pc;
  logic              pc_load_en;
  logic              pc_inc_en;

  // Jumps only take effect in IDLE; the increment lands on the edge that ends WRITE.
  assign pc_load_en = (state_q == StIdle) && bus.pc_load;
  assign pc_inc_en  = (state_q == StWrite);

  program_counter #(
    .ADDR_W (ADDR_W),
    .PC_STEP(PC_STEP)
  ) u_program_counter (
    .IR_clk    (IR_clk),
    .IR_rst    (IR_rst),
    .load_i    (pc_load_en),
    .load_val_i(bus.pc_load_val),
    .inc_i     (pc_inc_en),
    .pc_o      (pc)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  // Held at zero outside REQ so every REQ entry starts from a cleared count.
  always_ff @(posedge IR_clk or posedge IR_rst) begin
    if (IR_rst) begin
      cnt_q <= '0;
    end else if (state_q != StReq) begin
      cnt_q <= '0;
    end else if (!bus.mem_valid) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end
`endif

  always_ff @(posedge IR_clk or posedge IR_rst) begin
    if (IR_rst) begin
      state_q   <= StIdle;
      ir_data_q <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (bus.fetch_start) begin
            state_q <= StReq;
            rd_en_q <= 1'b1;
          end
        end
        StReq: begin
          // Valid data takes priority over a timeout expiring on the same edge.
          if (bus.mem_valid) begin
            ir_data_q <= bus.mem_rdata;
            state_q   <= StWrite;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b1;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_q <= StIdle;
            rd_en_q <= 1'b0;
            err_q   <= 1'b1;
          end
`endif
        end
        StWrite: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr   = pc;
  assign bus.pc         = pc;
  assign bus.mem_rd_en  = rd_en_q;
  assign bus.ir_data    = ir_data_q;
  assign bus.ir_wr_en   = wr_en_q;
  assign bus.fetch_done = wr_en_q;
  assign bus.fetch_busy = (state_q != StIdle);
`ifdef FETCH_TIMEOUT_EN
  assign bus.fetch_err  = err_q;
`else
  assign bus.fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 16;
  localparam int unsigned STEP = 1;
  localparam int unsigned TMO  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model state: what the PC and IR contents should be.
  logic [AW-1:0] pc_m;
  logic [DW-1:0] ir_m;

  instruction_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  instruction_fetch_unit #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .PC_STEP(STEP),
    .TIMEOUT(TMO)
  ) dut (
    .IR_clk(clk),
    .IR_rst(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.fetch_start = 1'b0;
    bus.pc_load     = 1'b0;
    bus.pc_load_val = '0;
    bus.mem_rdata   = '0;
    bus.mem_valid   = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.pc !== 8'h00 || bus.mem_addr !== 8'h00 || bus.ir_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_regs: pc=%h addr=%h ir=%h required 00 00 0000",
               bus.pc, bus.mem_addr, bus.ir_data);
    end
    checks++;
    if ({bus.mem_rd_en, bus.ir_wr_en, bus.fetch_busy, bus.fetch_done, bus.fetch_err} !== 5'b0)
    begin
      failures++;
      $display("FAIL reset_ctrl: rd,wr,busy,done,err=%b required 00000",
               {bus.mem_rd_en, bus.ir_wr_en, bus.fetch_busy, bus.fetch_done, bus.fetch_err});
    end
    rst  = 1'b0;
    pc_m = '0;
    ir_m = '0;
    tick();
  endtask

  // One complete fetch with `waits` memory wait cycles; caller must be in IDLE at #1.
  task automatic do_fetch(input int waits, input logic [DW-1:0] data, input bit load,
                          input logic [AW-1:0] lval, input bit noise);
    int rd_cycles;
    int start_cyc;
    rd_cycles = 0;
    bus.fetch_start = 1'b1;
    bus.pc_load     = load;
    bus.pc_load_val = lval;
    if (load) pc_m = lval;
    tick();
    start_cyc = cyc;
    bus.fetch_start = 1'b0;
    bus.pc_load     = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      checks++;
      if (bus.mem_rd_en !== 1'b1 || bus.ir_wr_en !== 1'b0 || bus.fetch_busy !== 1'b1 ||
          bus.mem_addr !== pc_m || bus.pc !== pc_m || bus.fetch_err !== 1'b0) begin
        failures++;
        $display("FAIL req_cycle%0d: rd=%b wr=%b busy=%b err=%b addr=%h pc=%h required 1 0 1 0 %h",
                 i, bus.mem_rd_en, bus.ir_wr_en, bus.fetch_busy, bus.fetch_err, bus.mem_addr,
                 bus.pc, pc_m);
      end
      if (bus.mem_rd_en === 1'b1) rd_cycles++;
      bus.mem_valid = (i == waits);
      bus.mem_rdata = (i == waits) ? data : DW'($urandom);
      if (noise) begin
        bus.fetch_start = 1'($urandom_range(0, 1));
        bus.pc_load     = 1'($urandom_range(0, 1));
        bus.pc_load_val = AW'($urandom);
      end
      tick();
    end
    bus.mem_valid   = 1'b0;
    bus.mem_rdata   = DW'($urandom);
    bus.fetch_start = 1'b0;
    bus.pc_load     = 1'b0;
    ir_m = data;
    checks++;
    if (bus.ir_wr_en !== 1'b1 || bus.fetch_done !== 1'b1 || bus.mem_rd_en !== 1'b0 ||
        bus.ir_data !== ir_m || bus.pc !== pc_m || bus.fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL write_cycle: wr=%b done=%b rd=%b err=%b ir=%h pc=%h required 1 1 0 0 %h %h",
               bus.ir_wr_en, bus.fetch_done, bus.mem_rd_en, bus.fetch_err, bus.ir_data, bus.pc,
               ir_m, pc_m);
    end
    checks++;
    if (cyc - start_cyc != waits + 1) begin
      failures++;
      $display("FAIL strobe_latency: %0d cycles after start edge required %0d",
               cyc - start_cyc + 1, waits + 2);
    end
    tick();
    pc_m = pc_m + AW'(STEP);
    checks++;
    if (bus.ir_wr_en !== 1'b0 || bus.fetch_done !== 1'b0 || bus.fetch_busy !== 1'b0 ||
        bus.pc !== pc_m || bus.mem_addr !== pc_m || bus.ir_data !== ir_m ||
        bus.fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL after_write: wr=%b done=%b busy=%b err=%b pc=%h addr=%h ir=%h required 0 0 0 0 %h %h %h",
               bus.ir_wr_en, bus.fetch_done, bus.fetch_busy, bus.fetch_err, bus.pc,
               bus.mem_addr, bus.ir_data, pc_m, pc_m, ir_m);
    end
    checks++;
    if (rd_cycles != waits + 1) begin
      failures++;
      $display("FAIL rd_en_cycles: %0d required %0d", rd_cycles, waits + 1);
    end
  endtask

  task automatic test_zero_wait();
    do_fetch(0, 16'hA55A, 1'b0, '0, 1'b0);
    checks++;
    if (bus.ir_data !== 16'hA55A || bus.pc !== 8'h01) begin
      failures++;
      $display("FAIL zero_wait: ir=%h pc=%h required a55a 01", bus.ir_data, bus.pc);
    end
  endtask

  task automatic test_wait_states();
    do_fetch(3, DW'($urandom), 1'b0, '0, 1'b0);
  endtask

  task automatic test_jump();
    do_fetch(0, DW'($urandom), 1'b1, 8'h40, 1'b0);
    checks++;
    if (bus.pc !== 8'h41) begin
      failures++;
      $display("FAIL jump: pc=%h required 41", bus.pc);
    end
  endtask

  task automatic test_wrap();
    bus.pc_load     = 1'b1;
    bus.pc_load_val = 8'hFF;
    tick();
    bus.pc_load = 1'b0;
    pc_m = 8'hFF;
    checks++;
    if (bus.pc !== 8'hFF || bus.fetch_busy !== 1'b0) begin
      failures++;
      $display("FAIL load_only: pc=%h busy=%b required ff 0", bus.pc, bus.fetch_busy);
    end
    do_fetch(2, DW'($urandom), 1'b0, '0, 1'b1);
    checks++;
    if (bus.pc !== 8'h00) begin
      failures++;
      $display("FAIL wrap: pc=%h required 00", bus.pc);
    end
  endtask

  task automatic test_reset_mid_fetch();
    bus.fetch_start = 1'b1;
    bus.pc_load     = 1'b1;
    bus.pc_load_val = 8'h5C;
    tick();
    bus.fetch_start = 1'b0;
    bus.pc_load     = 1'b0;
    bus.mem_valid   = 1'b0;
    tick();
    checks++;
    if (bus.mem_rd_en !== 1'b1 || bus.pc !== 8'h5C) begin
      failures++;
      $display("FAIL pre_reset_req: rd=%b pc=%h required 1 5c", bus.mem_rd_en, bus.pc);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.pc !== 8'h00 || bus.mem_addr !== 8'h00 || bus.ir_data !== 16'h0000 ||
        {bus.mem_rd_en, bus.ir_wr_en, bus.fetch_busy, bus.fetch_done, bus.fetch_err} !== 5'b0)
    begin
      failures++;
      $display("FAIL async_reset: pc=%h addr=%h ir=%h rd,wr,busy,done,err=%b required all 0",
               bus.pc, bus.mem_addr, bus.ir_data,
               {bus.mem_rd_en, bus.ir_wr_en, bus.fetch_busy, bus.fetch_done, bus.fetch_err});
    end
    pc_m = '0;
    ir_m = '0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.ir_wr_en !== 1'b0 || bus.fetch_busy !== 1'b0 || bus.pc !== 8'h00) begin
      failures++;
      $display("FAIL post_reset_idle: wr=%b busy=%b pc=%h required 0 0 00",
               bus.ir_wr_en, bus.fetch_busy, bus.pc);
    end
    do_fetch(1, DW'($urandom), 1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 24; n++) begin
      do_fetch(int'($urandom_range(0, 4)), DW'($urandom), ($urandom_range(0, 3) == 0),
               AW'($urandom), 1'b1);
    end
  endtask

  task automatic test_long_wait();
`ifdef FETCH_TIMEOUT_EN
    logic [AW-1:0] pc_before;
    pc_before = pc_m;
    bus.fetch_start = 1'b1;
    tick();
    bus.fetch_start = 1'b0;
    bus.mem_valid   = 1'b0;
    for (int i = 0; i < int'(TMO); i++) begin
      checks++;
      if (bus.mem_rd_en !== 1'b1 || bus.fetch_err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait%0d: rd=%b err=%b required 1 0", i, bus.mem_rd_en,
                 bus.fetch_err);
      end
      tick();
    end
    checks++;
    if (bus.fetch_err !== 1'b1 || bus.fetch_busy !== 1'b0 || bus.mem_rd_en !== 1'b0 ||
        bus.ir_wr_en !== 1'b0 || bus.pc !== pc_before || bus.ir_data !== ir_m) begin
      failures++;
      $display("FAIL timeout_expiry: err=%b busy=%b rd=%b wr=%b pc=%h ir=%h required 1 0 0 0 %h %h",
               bus.fetch_err, bus.fetch_busy, bus.mem_rd_en, bus.ir_wr_en, bus.pc, bus.ir_data,
               pc_before, ir_m);
    end
    tick();
    checks++;
    if (bus.fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse: err=%b required 0", bus.fetch_err);
    end
    // Data on the expiry edge must win over the timeout.
    do_fetch(int'(TMO) - 1, DW'($urandom), 1'b0, '0, 1'b0);
`else
    // No timeout exists: a wait well beyond TIMEOUT must still complete normally.
    do_fetch(int'(TMO) + 5, DW'($urandom), 1'b0, '0, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_jump();
    test_wrap();
    test_reset_mid_fetch();
    test_back_to_back();
    test_long_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
